// File: rtl/mouse_pos_tracker_if.sv
// Packet-in / position-out bundle between the PS/2 packet decoder and the cursor tracker.
`default_nettype none

interface mouse_pos_tracker_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [8:0]  dx;
  logic [8:0]  dy;
  logic        x_ovf;
  logic        y_ovf;
  logic        btn_left;
  logic        btn_right;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        pos_valid;
  logic        left_click;
  logic        right_click;

  // Packet source / position consumer side
  modport master (
    output pkt_valid, dx, dy, x_ovf, y_ovf, btn_left, btn_right,
    input  pkt_ready, xpos, ypos, pos_valid, left_click, right_click
  );

  // Tracker side
  modport slave (
    input  pkt_valid, dx, dy, x_ovf, y_ovf, btn_left, btn_right,
    output pkt_ready, xpos, ypos, pos_valid, left_click, right_click
  );
endinterface

`default_nettype wire

// File: rtl/mouse_pos_tracker.sv
// Accumulates relative PS/2 mouse motion into screen-clamped absolute coordinates
// and emits one-cycle click pulses on button rising edges.
`default_nettype none

module mouse_pos_tracker #(
  parameter int X_MAX        = 1279,
  parameter int Y_MAX        = 719,
  parameter int MOTION_SHIFT = 0
) (
  input  wire logic           clk100MHz,
  input  wire logic           rst,
  mouse_pos_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_APPLY_X = 2'd1,
    S_APPLY_Y = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  localparam logic [11:0]        XPOS_RST = 12'(X_MAX / 2);
  localparam logic [11:0]        YPOS_RST = 12'(Y_MAX / 2);
  localparam logic signed [13:0] X_LIM    = 14'(X_MAX);
  localparam logic signed [13:0] Y_LIM    = 14'(Y_MAX);

  state_t      state_q;
  logic [8:0]  dx_q, dy_q;
  logic        x_ovf_q, y_ovf_q;
  logic        btn_left_q, btn_right_q;
  logic        prev_left_q, prev_right_q;
  logic [11:0] xpos_q, ypos_q;
  logic [11:0] x_next_q, y_next_q;
  logic        pkt_ready_q;
  logic        pos_valid_q;
  logic        left_click_q, right_click_q;

  logic signed [13:0] dx_ext, dy_ext;
  logic signed [13:0] x_sum_d, y_sum_d;
  logic [11:0]        x_next_d, y_next_d;

  assign dx_ext = {{5{dx_q[8]}}, dx_q};
  assign dy_ext = {{5{dy_q[8]}}, dy_q};

  // Y is subtracted: mouse +dy is up, screen row 0 is the top.
  always_comb begin
    x_sum_d = $signed({2'b00, xpos_q}) + (dx_ext <<< MOTION_SHIFT);
    y_sum_d = $signed({2'b00, ypos_q}) - (dy_ext <<< MOTION_SHIFT);

    x_next_d = x_sum_d[11:0];
    if (x_ovf_q)
      x_next_d = xpos_q;
    else if (x_sum_d[13])
      x_next_d = 12'd0;
    else if (x_sum_d > X_LIM)
      x_next_d = X_LIM[11:0];

    y_next_d = y_sum_d[11:0];
    if (y_ovf_q)
      y_next_d = ypos_q;
    else if (y_sum_d[13])
      y_next_d = 12'd0;
    else if (y_sum_d > Y_LIM)
      y_next_d = Y_LIM[11:0];
  end

  // xpos/ypos are written only in PUBLISH so the downstream CDC sees stable values.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dx_q          <= '0;
      dy_q          <= '0;
      x_ovf_q       <= 1'b0;
      y_ovf_q       <= 1'b0;
      btn_left_q    <= 1'b0;
      btn_right_q   <= 1'b0;
      prev_left_q   <= 1'b0;
      prev_right_q  <= 1'b0;
      xpos_q        <= XPOS_RST;
      ypos_q        <= YPOS_RST;
      x_next_q      <= XPOS_RST;
      y_next_q      <= YPOS_RST;
      pkt_ready_q   <= 1'b1;
      pos_valid_q   <= 1'b0;
      left_click_q  <= 1'b0;
      right_click_q <= 1'b0;
    end else begin
      pos_valid_q   <= 1'b0;
      left_click_q  <= 1'b0;
      right_click_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.pkt_valid) begin
            dx_q        <= bus.dx;
            dy_q        <= bus.dy;
            x_ovf_q     <= bus.x_ovf;
            y_ovf_q     <= bus.y_ovf;
            btn_left_q  <= bus.btn_left;
            btn_right_q <= bus.btn_right;
            pkt_ready_q <= 1'b0;
            state_q     <= S_APPLY_X;
          end
        end
        S_APPLY_X: begin
          x_next_q <= x_next_d;
          state_q  <= S_APPLY_Y;
        end
        S_APPLY_Y: begin
          y_next_q <= y_next_d;
          state_q  <= S_PUBLISH;
        end
        S_PUBLISH: begin
          xpos_q        <= x_next_q;
          ypos_q        <= y_next_q;
          pos_valid_q   <= 1'b1;
          left_click_q  <= btn_left_q & ~prev_left_q;
          right_click_q <= btn_right_q & ~prev_right_q;
          prev_left_q   <= btn_left_q;
          prev_right_q  <= btn_right_q;
          pkt_ready_q   <= 1'b1;
          state_q       <= S_IDLE;
        end
        default: begin
          pkt_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pkt_ready   = pkt_ready_q;
  assign bus.xpos        = xpos_q;
  assign bus.ypos        = ypos_q;
  assign bus.pos_valid   = pos_valid_q;
  assign bus.left_click  = left_click_q;
  assign bus.right_click = right_click_q;

endmodule

`default_nettype wire

// File: tb/tb_mouse_pos_tracker.sv
// Randomized + directed bench for mouse_pos_tracker against an integer cursor model.
`default_nettype none

module tb_mouse_pos_tracker;

  localparam int X_MAX = 1279;
  localparam int Y_MAX = 719;
  localparam int SHIFT = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int  m_x = X_MAX / 2;
  int  m_y = Y_MAX / 2;
  bit  m_pl = 1'b0;
  bit  m_pr = 1'b0;

  always #5 clk = ~clk;

  mouse_pos_tracker_if bus ();

  mouse_pos_tracker #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .MOTION_SHIFT(SHIFT)
  ) dut (
    .clk100MHz(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int to_signed9(input logic [8:0] v);
    return v[8] ? int'(v) - 512 : int'(v);
  endfunction

  task automatic model_reset();
    m_x = X_MAX / 2; m_y = Y_MAX / 2; m_pl = 0; m_pr = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_xpos"}, int'(bus.xpos), m_x);
    chk({tag, "_ypos"}, int'(bus.ypos), m_y);
    chk({tag, "_pos_valid"}, int'(bus.pos_valid), 0);
    chk({tag, "_lclick"}, int'(bus.left_click), 0);
    chk({tag, "_rclick"}, int'(bus.right_click), 0);
    chk({tag, "_ready"}, int'(bus.pkt_ready), 1);
  endtask

  // Offer one packet; optionally keep pkt_valid high while the tracker is busy.
  task automatic send(input logic [8:0] dx, input logic [8:0] dy, input bit xo, input bit yo,
                      input bit bl, input bit br, input bit hold);
    int ex, ey, elc, erc, waited;
    waited = 0;
    @(negedge clk);
    while (bus.pkt_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.pkt_ready !== 1'b1) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    bus.dx = dx; bus.dy = dy; bus.x_ovf = xo; bus.y_ovf = yo;
    bus.btn_left = bl; bus.btn_right = br; bus.pkt_valid = 1'b1;

    ex  = xo ? m_x : clamp(m_x + to_signed9(dx) * (1 << SHIFT), X_MAX);
    ey  = yo ? m_y : clamp(m_y - to_signed9(dy) * (1 << SHIFT), Y_MAX);
    elc = (bl && !m_pl) ? 1 : 0;
    erc = (br && !m_pr) ? 1 : 0;

    @(posedge clk); #1;
    if (!hold) bus.pkt_valid = 1'b0;
    chk("busy_ready", int'(bus.pkt_ready), 0);
    for (int i = 1; i <= 2; i++) begin
      chk("early_pos_valid", int'(bus.pos_valid), 0);
      chk("stable_xpos", int'(bus.xpos), m_x);
      chk("stable_ypos", int'(bus.ypos), m_y);
      @(posedge clk); #1;
    end
    chk("early_pos_valid", int'(bus.pos_valid), 0);
    @(posedge clk); #1;
    chk("pos_valid", int'(bus.pos_valid), 1);
    chk("xpos", int'(bus.xpos), ex);
    chk("ypos", int'(bus.ypos), ey);
    chk("left_click", int'(bus.left_click), elc);
    chk("right_click", int'(bus.right_click), erc);
    bus.pkt_valid = 1'b0;
    m_x = ex; m_y = ey; m_pl = bl; m_pr = br;

    @(posedge clk); #1;
    chk("pulse_width", int'(bus.pos_valid), 0);
    chk("single_update_x", int'(bus.xpos), m_x);
    chk("single_update_y", int'(bus.ypos), m_y);
  endtask

  initial begin
    bus.pkt_valid = 1'b0; bus.dx = '0; bus.dy = '0; bus.x_ovf = 1'b0; bus.y_ovf = 1'b0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // Basic motion
    send(9'd10, 9'd5, 0, 0, 0, 0, 0);

    // Left clamp, then Y clamp both ways
    repeat (3) send(9'h101, 9'd0, 0, 0, 0, 0, 0);
    send(9'h1FF, 9'd0, 0, 0, 0, 0, 0);
    repeat (3) send(9'd0, 9'h101, 0, 0, 0, 0, 0);
    repeat (4) send(9'd0, 9'd255, 0, 0, 0, 0, 0);
    repeat (6) send(9'd255, 9'd0, 0, 0, 0, 0, 0);

    // Overflow discard with pkt_valid held during busy
    send(9'd100, 9'd10, 1, 0, 0, 0, 1);
    send(9'd20, 9'd30, 0, 1, 0, 0, 1);

    // Click edge behaviour
    send(9'd0, 9'd0, 0, 0, 1, 0, 0);
    send(9'd0, 9'd0, 0, 0, 1, 0, 0);
    send(9'd0, 9'd0, 0, 0, 0, 0, 0);
    send(9'd0, 9'd0, 0, 0, 1, 1, 0);
    send(9'd3, 9'd3, 0, 0, 1, 1, 0);

    // Reset while in APPLY_Y discards the packet
    @(negedge clk);
    bus.dx = 9'd50; bus.dy = 9'd50; bus.btn_left = 1'b0; bus.btn_right = 1'b1;
    bus.pkt_valid = 1'b1;
    @(posedge clk); #1;
    bus.pkt_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_idle_outputs("mid_reset");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_reset_no_pulse", int'(bus.pos_valid), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("after_mid_reset");
    send(9'd0, 9'd0, 0, 0, 0, 1, 0);

    // Randomized packets
    for (int n = 0; n < 300; n++) begin
      send(9'($urandom), 9'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
